// File: rtl/cross_bar_pkg.sv
// Shared crossbar types and constants: address/data widths, slave FSM encoding
// and the default read data returned for out-of-range slave accesses.
package cross_bar_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SLAVE_W = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } slv_state_t;

    localparam data_t SLV_ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/cross_bar_slave_ram.sv
// Single-port word RAM: synchronous write, synchronous read with one-cycle latency.
module cross_bar_slave_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage array write and registered read port; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cross_bar_slave_mem.sv
// Memory-backed crossbar slave: captures one request, waits WAIT_CYCLES,
// pulses ack for one cycle and completes a word write or read on a local RAM.
module cross_bar_slave_mem
    import cross_bar_pkg::*;
#(
    parameter int    MEM_AW      = 8,
    parameter int    WAIT_CYCLES = 2,
    parameter data_t ERR_DATA    = SLV_ERR_DATA_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  slave_req,
    input  addr_t slave_addr,
    input  logic  slave_cmd,
    input  data_t slave_wdata,
    output logic  slave_ack,
    output data_t slave_rdata
);

    localparam int OFF_HI = ADDR_W - SLAVE_W - 1;
    localparam int OFF_LO = MEM_AW + 2;

    slv_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    addr_t             addr_q;
    logic              cmd_q;
    data_t             wdata_q;
    logic              ack_q;
    data_t             rdata_q;

    logic              capture;
    logic              oor;
    logic [MEM_AW-1:0] ram_addr;
    logic              ram_we;
    logic              ram_re;
    data_t             ram_rdata;
    data_t             rd_val;
    logic              unused_addr_bits;

    // Port-index bits and the byte offset play no part in the local access.
    assign unused_addr_bits = ^{slave_addr[ADDR_W-1:ADDR_W-SLAVE_W], slave_addr[1:0],
                                addr_q[ADDR_W-1:ADDR_W-SLAVE_W], addr_q[1:0]};

    // Next-state logic: capture in IDLE, count wait states, single ACK, hold in DONE until req drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (slave_req) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ACK;
                end
            end
            ACK:     state_d = DONE;
            DONE:    if (!slave_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM read is launched on the cycle before ACK so its data lands in the ACK cycle;
    // with zero wait states that is the capture cycle, so the live address is used.
    assign oor      = (addr_q[OFF_HI:OFF_LO] != '0);
    assign ram_re   = (state_d == ACK);
    assign ram_addr = capture ? slave_addr[MEM_AW+1:2] : addr_q[MEM_AW+1:2];
    assign ram_we   = (state_q == ACK) && cmd_q && !oor && !reset;
    assign rd_val   = oor ? ERR_DATA : ram_rdata;

    // Control registers: FSM state, wait counter, ack pulse and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == ACK);
            if (ack_q && !cmd_q) begin
                rdata_q <= rd_val;
            end
        end
    end

    // Request latch: address, command and write data are frozen at capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= slave_addr;
            cmd_q   <= slave_cmd;
            wdata_q <= slave_wdata;
        end
    end

    cross_bar_slave_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // During the read ack cycle the fresh RAM word is presented; otherwise the last read is held.
    assign slave_ack   = ack_q;
    assign slave_rdata = (ack_q && !cmd_q) ? rd_val : rdata_q;

endmodule
